// File: rtl/hash_result_writer_pkg.sv
// Shared types for the hash result writer: FSM states and the FIFO entry layout.
package hash_result_writer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wr_state_t;

  localparam int NUM_NONCES_DEF = 16;
  localparam int ENTRY_W        = 40;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/hash_result_writer_if.sv
// Job control, hash word handshake and memory write port of the hash result writer.
interface hash_result_writer_if #(
  parameter int ADDR_W = 16
) ();
  logic              start;
  logic [ADDR_W-1:0] output_addr;
  logic              hash_valid;
  logic [31:0]       hash_data;
  logic [7:0]        hash_idx;
  logic              hash_ready;
  logic              mem_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic              done;
  logic              err;

  modport slave (
    input  start, output_addr, hash_valid, hash_data, hash_idx, mem_busy,
    output hash_ready, mem_we, mem_addr, mem_write_data, done, err
  );

  modport master (
    output start, output_addr, hash_valid, hash_data, hash_idx, mem_busy,
    input  hash_ready, mem_we, mem_addr, mem_write_data, done, err
  );
endinterface

// File: rtl/hash_result_writer_sync_fifo.sv
// Synchronous FIFO with registered read data; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (do_pop) rd_data <= mem[rd_ptr[AW-1:0]];
  end
endmodule

// File: rtl/hash_result_writer.sv
// Collects per-nonce H0 words, buffers them, and writes each to base + nonce index.
module hash_result_writer
  import hash_result_writer_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 16
) (
  input logic                  clk,
  input logic                  reset,
  hash_result_writer_if.slave  bus
);
  localparam int                CNT_W   = $clog2(NUM_NONCES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NUM_NONCES);
  localparam logic [8:0]        IDX_LIM = 9'(NUM_NONCES);

  wr_state_t         state_q;
  wr_state_t         state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              err_q;

  logic              ready;
  logic              done_c;
  logic              start_ok;
  logic              accept;
  logic              idx_ok;
  logic              push;
  logic              pop;
  logic              issue;
  logic              fifo_full;
  logic              fifo_empty;
  fifo_entry_t       entry_p0;
  logic [ENTRY_W-1:0] rd_raw;
  fifo_entry_t       entry_p1;
  logic              vld_p1;
  logic              mem_we_p2;
  logic [ADDR_W-1:0] mem_addr_p2;
  logic [31:0]       mem_data_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    done_c   = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        ready = !fifo_full && (acc_cnt_q < CNT_MAX);
        if (acc_cnt_q == CNT_MAX) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt_q == CNT_MAX) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: accept and push into the FIFO; out-of-range indices are dropped here
  assign accept   = bus.hash_valid && ready;
  assign idx_ok   = {1'b0, bus.hash_idx} < IDX_LIM;
  assign push     = accept && idx_ok;
  assign entry_p0 = '{idx: bus.hash_idx, data: bus.hash_data};
  assign pop      = ((state_q == RUN) || (state_q == DRAIN)) && !fifo_empty && !bus.mem_busy;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (entry_p0),
    .pop     (pop),
    .rd_data (rd_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // p1: popped entry waits here until the write port is free
  assign entry_p1 = fifo_entry_t'(rd_raw);
  assign issue    = vld_p1 && !bus.mem_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      if (start_ok) begin
        base_q    <= bus.output_addr;
        acc_cnt_q <= '0;
        wr_cnt_q  <= '0;
        err_q     <= 1'b0;
      end else begin
        if (push)              acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        if (accept && !idx_ok) err_q     <= 1'b1;
        if (issue)             wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
      end
      if (pop)        vld_p1 <= 1'b1;
      else if (issue) vld_p1 <= 1'b0;
    end
  end

  // p2: registered memory write port; address wraps modulo 2^ADDR_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_p2   <= 1'b0;
      mem_addr_p2 <= '0;
      mem_data_p2 <= '0;
    end else begin
      mem_we_p2 <= issue;
      if (issue) begin
        mem_addr_p2 <= base_q + ADDR_W'(entry_p1.idx);
        mem_data_p2 <= entry_p1.data;
      end
    end
  end

  assign bus.hash_ready     = ready;
  assign bus.done           = done_c;
  assign bus.err            = err_q;
  assign bus.mem_we         = mem_we_p2;
  assign bus.mem_addr       = mem_addr_p2;
  assign bus.mem_write_data = mem_data_p2;
endmodule

// File: tb/tb_hash_result_writer.sv
// Directed bench for hash_result_writer: job table plus reset/idle corner sequences.
module tb_hash_result_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hash_result_writer_if #(.ADDR_W(16)) bus ();

  hash_result_writer #(
    .NUM_NONCES (16),
    .DEPTH      (4),
    .ADDR_W     (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] base;
    bit          rev;
    int          busy_at;
    int          busy_len;
    int          bad_pos;
    logic [7:0]  bad_idx;
    bit          restart_mid;
    bit          exp_err;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    bit          exp_b2b;
  } job_t;

  job_t jobs[6];

  int n_checks = 0;
  int n_fail   = 0;

  int   cyc = 0;
  logic busy_s = 1'b0;
  logic [15:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_cyc[$];
  int done_cnt  = 0;
  int done_cyc  = 0;
  int busy_viol = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_s <= bus.mem_busy;
  end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      cap_addr.push_back(bus.mem_addr);
      cap_data.push_back(bus.mem_write_data);
      cap_cyc.push_back(cyc);
      if (busy_s) busy_viol <= busy_viol + 1;
    end
    if (bus.done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input int j);
    job_t        jb;
    logic [7:0]  widx[17];
    logic [7:0]  eidx[16];
    int          nw, k, cb, db, vb, first_acc, nwr, t, last;
    logic [15:0] ea;
    jb = jobs[j];
    nw = (jb.bad_pos >= 0) ? 17 : 16;
    k  = 0;
    for (int n = 0; n < nw; n++) begin
      if (n == jb.bad_pos) begin
        widx[n] = jb.bad_idx;
      end else begin
        widx[n] = jb.rev ? 8'(15 - k) : 8'(k);
        eidx[k] = widx[n];
        k++;
      end
    end
    cb = cap_addr.size();
    db = done_cnt;
    vb = busy_viol;
    first_acc = -1;

    bus.start       = 1'b1;
    bus.output_addr = jb.base;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check($sformatf("job%0d err_cleared", j), bus.err, 0);
    check($sformatf("job%0d ready_in_run", j), bus.hash_ready, 1);

    fork
      begin
        for (int n = 0; n < nw; n++) begin
          int tt;
          bit got;
          bus.hash_valid = 1'b1;
          bus.hash_idx   = widx[n];
          bus.hash_data  = {16'hDA7A, 8'(j), widx[n]};
          got = 1'b0;
          tt  = 0;
          while (!got && tt < 100) begin
            @(negedge clk);
            got = bus.hash_ready;
            @(posedge clk); #1;
            tt++;
          end
          if (!got) begin
            check($sformatf("job%0d accept_timeout", j), got, 1);
            break;
          end
          if (n == 0) first_acc = cyc;
        end
        bus.hash_valid = 1'b0;
      end
      begin
        if (jb.busy_len > 0) begin
          repeat (jb.busy_at) @(posedge clk);
          #1 bus.mem_busy = 1'b1;
          repeat (jb.busy_len - 1) @(posedge clk);
          @(negedge clk);
          check($sformatf("job%0d ready_low_when_full", j), bus.hash_ready, 0);
          @(posedge clk);
          #1 bus.mem_busy = 1'b0;
        end
      end
      begin
        if (jb.restart_mid) begin
          repeat (5) @(posedge clk);
          #1;
          bus.start       = 1'b1;
          bus.output_addr = 16'h7777;
          @(posedge clk); #1;
          bus.start       = 1'b0;
          bus.output_addr = jb.base;
        end
      end
    join

    t = 0;
    while (done_cnt == db && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == db) check($sformatf("job%0d done_timeout", j), done_cnt - db, 1);
    repeat (3) @(posedge clk);
    #1;

    nwr = cap_addr.size() - cb;
    check($sformatf("job%0d write_count", j), nwr, 16);
    for (int n = 0; n < 16 && n < nwr; n++) begin
      ea = jb.base + 16'(eidx[n]);
      check($sformatf("job%0d addr[%0d]", j, n), cap_addr[cb + n], ea);
      check($sformatf("job%0d data[%0d]", j, n), cap_data[cb + n], {16'hDA7A, 8'(j), eidx[n]});
    end
    if (nwr > 0) begin
      last = cb + nwr - 1;
      check($sformatf("job%0d first_addr", j), cap_addr[cb], jb.exp_first);
      check($sformatf("job%0d last_addr", j), cap_addr[last], jb.exp_last);
      check($sformatf("job%0d first_latency", j), cap_cyc[cb] - first_acc, 2);
      check($sformatf("job%0d done_after_last_write", j), done_cyc - cap_cyc[last], 1);
      if (jb.exp_b2b)
        check($sformatf("job%0d write_span", j), cap_cyc[last] - cap_cyc[cb], 15);
    end
    check($sformatf("job%0d done_pulses", j), done_cnt - db, 1);
    check($sformatf("job%0d err_held", j), bus.err, jb.exp_err);
    check($sformatf("job%0d ready_idle", j), bus.hash_ready, 0);
    check($sformatf("job%0d write_while_busy", j), busy_viol - vb, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cb, k, t;
    bit  got;

    jobs[0] = '{16'h0100, 1'b0, 0, 0,  -1, 8'd0,  1'b0, 1'b0, 16'h0100, 16'h010F, 1'b1};
    jobs[1] = '{16'h0300, 1'b0, 8, 10, -1, 8'd0,  1'b0, 1'b0, 16'h0300, 16'h030F, 1'b0};
    jobs[2] = '{16'hFFF8, 1'b0, 0, 0,  -1, 8'd0,  1'b0, 1'b0, 16'hFFF8, 16'h0007, 1'b1};
    jobs[3] = '{16'h0400, 1'b0, 0, 0,   7, 8'd20, 1'b0, 1'b1, 16'h0400, 16'h040F, 1'b0};
    jobs[4] = '{16'h1000, 1'b1, 0, 0,  -1, 8'd0,  1'b1, 1'b0, 16'h100F, 16'h1000, 1'b1};
    jobs[5] = '{16'h0200, 1'b0, 0, 0,  -1, 8'd0,  1'b0, 1'b0, 16'h0200, 16'h020F, 1'b1};

    bus.start       = 1'b0;
    bus.output_addr = '0;
    bus.hash_valid  = 1'b0;
    bus.hash_data   = '0;
    bus.hash_idx    = '0;
    bus.mem_busy    = 1'b0;

    #1;
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_write_data", bus.mem_write_data, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    check("reset hash_ready", bus.hash_ready, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // hash_valid while IDLE must be ignored
    bus.hash_valid = 1'b1;
    bus.hash_idx   = 8'd2;
    bus.hash_data  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle ready[%0d]", i), bus.hash_ready, 0);
      @(posedge clk); #1;
    end
    bus.hash_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle no_writes", cap_addr.size(), 0);

    for (int j = 0; j < 5; j++) run_job(j);

    // reset mid-job after 5 writes, then a fresh job
    cb = cap_addr.size();
    bus.start       = 1'b1;
    bus.output_addr = jobs[5].base;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    t = 0;
    while ((cap_addr.size() - cb) < 5 && t < 100) begin
      bus.hash_valid = 1'b1;
      bus.hash_idx   = 8'(k);
      bus.hash_data  = {16'hBEEF, 8'(k), 8'(k)};
      @(negedge clk);
      got = bus.hash_ready;
      @(posedge clk); #1;
      if (got) k++;
      t++;
    end
    check("mid writes_before_reset", (cap_addr.size() - cb) >= 5, 1);
    #3 reset = 1'b1;
    #1;
    check("mid reset mem_we", bus.mem_we, 0);
    check("mid reset hash_ready", bus.hash_ready, 0);
    check("mid reset done", bus.done, 0);
    check("mid reset mem_addr", bus.mem_addr, 0);
    bus.hash_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post reset idle ready", bus.hash_ready, 0);
    run_job(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
